// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single registered ALU: IDLE -> ISSUE -> WAIT, one op in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins ties (no round-robin pointer).
module alu_arbiter #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       CODE_W    = 4,
    parameter logic [CODE_W-1:0] IDLE_CODE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [WIDTH-1:0]  a0,
    input  logic [WIDTH-1:0]  a1,
    input  logic [WIDTH-1:0]  b0,
    input  logic [WIDTH-1:0]  b1,
    input  logic [CODE_W-1:0] code0,
    input  logic [CODE_W-1:0] code1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [WIDTH-1:0]  res_out,
    output logic              zero_out,
    output logic [WIDTH-1:0]  alu_one,
    output logic [WIDTH-1:0]  alu_two,
    output logic [CODE_W-1:0] alu_code,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic                zero_q, zero_d;
    logic [WIDTH-1:0]    one_q, one_d;
    logic [WIDTH-1:0]    two_q, two_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                pick1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    // last_q = 1 means port 1 was granted most recently; resets to 1 so port 0 wins the first tie
    logic                last_q, last_d;
`endif

    always_comb begin
        pick1 = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        pick1 = req1 & ~req0;
`else
        pick1 = req1 & (~req0 | ~last_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        res_d   = res_q;
        zero_d  = zero_q;
        one_d   = one_q;
        two_d   = two_q;
        code_d  = code_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d = S_ISSUE;
                    sel_d   = pick1;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    one_d   = pick1 ? a1 : a0;
                    two_d   = pick1 ? b1 : b0;
                    code_d  = pick1 ? code1 : code0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = pick1;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ALU registered the operands at the end of ISSUE; its result is valid now
                state_d = S_IDLE;
                res_d   = alu_result;
                zero_d  = alu_zero;
                done0_d = ~sel_q;
                done1_d = sel_q;
                code_d  = IDLE_CODE;
            end
            default: begin
                state_d = S_IDLE;
                code_d  = IDLE_CODE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            one_q   <= '0;
            two_q   <= '0;
            code_q  <= IDLE_CODE;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            one_q   <= one_d;
            two_q   <= two_d;
            code_q  <= code_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign res_out  = res_q;
    assign zero_out = zero_q;
    assign alu_one  = one_q;
    assign alu_two  = two_q;
    assign alu_code = code_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small registered ALU model on the alu_* interface.
module tb_alu_arbiter;

    localparam int unsigned W = 32;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b1010;
    localparam logic [3:0] C_MOV  = 4'b1101;
    localparam logic [3:0] C_IDLE = 4'b0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [W-1:0]  a0, a1, b0, b1;
    logic [3:0]    code0, code1;
    logic          gnt0, gnt1, done0, done1, zero_out;
    logic [W-1:0]  res_out, alu_one, alu_two;
    logic [3:0]    alu_code;
    logic [W-1:0]  alu_result = '0;
    logic          alu_zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         port;
        logic [W-1:0] res;
        logic         zero;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;
    logic last_port;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(W), .CODE_W(4), .IDLE_CODE(C_IDLE)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .code0(code0), .code1(code1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res_out(res_out), .zero_out(zero_out),
        .alu_one(alu_one), .alu_two(alu_two), .alu_code(alu_code),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [3:0] c);
        case (c)
            C_ADD:   return x + y;
            C_SUB:   return x - y;
            C_MOV:   return x;
            default: return '0;
        endcase
    endfunction

    always @(posedge clock) begin
        alu_result <= alu_f(alu_one, alu_two, alu_code);
        alu_zero   <= (alu_f(alu_one, alu_two, alu_code) == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected op
    always @(negedge clock) begin
        if (!reset) begin
            check("gnt_excl", 64'(gnt0 & gnt1), 64'd0);
            check("done_excl", 64'(done0 & done1), 64'd0);
            if (done0 || done1) begin
                check("sb_nonempty_at_done", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("done_port", 64'(done1), 64'(mon_e.port));
                    check("res_out", 64'(res_out), 64'(mon_e.res));
                    check("zero_out", 64'(zero_out), 64'(mon_e.zero));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_req(input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] c);
        if (!p) begin
            req0 = 1'b1; a0 = a; b0 = b; code0 = c;
        end else begin
            req1 = 1'b1; a1 = a; b1 = b; code1 = c;
        end
    endtask

    task automatic push_exp(input logic p, input logic [W-1:0] r, input logic z);
        exp_t e;
        e.port = p; e.res = r; e.zero = z;
        sb_q.push_back(e);
        last_port = p;
    endtask

    task automatic single_op(input string t, input logic p, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [3:0] c,
                             input logic [W-1:0] r, input logic z);
        set_req(p, a, b, c);
        push_exp(p, r, z);
        tick();
        check({t, "_gnt0_c1"}, 64'(gnt0), 64'(!p));
        check({t, "_gnt1_c1"}, 64'(gnt1), 64'(p));
        check({t, "_code_c1"}, 64'(alu_code), 64'(c));
        check({t, "_one_c1"}, 64'(alu_one), 64'(a));
        check({t, "_two_c1"}, 64'(alu_two), 64'(b));
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check({t, "_gnt_c2"}, 64'(gnt0 | gnt1), 64'd0);
        check({t, "_done_c2"}, 64'(done0 | done1), 64'd0);
        check({t, "_code_c2"}, 64'(alu_code), 64'(c));
        tick();
        check({t, "_done0_c3"}, 64'(done0), 64'(!p));
        check({t, "_done1_c3"}, 64'(done1), 64'(p));
        check({t, "_code_c3"}, 64'(alu_code), 64'(C_IDLE));
        check({t, "_one_hold_c3"}, 64'(alu_one), 64'(a));
    endtask

    // Both ports request continuously; operands must already be on a0/b0/code0 and a1/b1/code1
    task automatic tie_run(input string t, input int n, input logic [W-1:0] r0, input logic z0,
                           input logic [W-1:0] r1, input logic z1);
        logic ep [16];
        int   k;
        for (int i = 0; i < n; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            ep[i] = 1'b0;
`else
            ep[i] = ~last_port;
`endif
            if (ep[i]) push_exp(1'b1, r1, z1);
            else       push_exp(1'b0, r0, z0);
        end
        k = 0;
        req0 = 1'b1; req1 = 1'b1;
        for (int cyc = 1; cyc <= 3 * n; cyc++) begin
            tick();
            if ((cyc - 1) % 3 == 0) begin
                check({t, "_gnt0"}, 64'(gnt0), 64'(!ep[k]));
                check({t, "_gnt1"}, 64'(gnt1), 64'(ep[k]));
                check({t, "_code"}, 64'(alu_code), 64'(ep[k] ? code1 : code0));
                k++;
            end else begin
                check({t, "_no_gnt"}, 64'(gnt0 | gnt1), 64'd0);
            end
            if (cyc == 3 * n) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        tick();
        check({t, "_quiet_after"}, 64'(gnt0 | gnt1), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; code0 = '0; code1 = '0;
        last_port = 1'b1;
        repeat (2) @(negedge clock);

        check("rst_gnt", 64'({gnt0, gnt1}), 64'd0);
        check("rst_done", 64'({done0, done1}), 64'd0);
        check("rst_res", 64'(res_out), 64'd0);
        check("rst_zero", 64'(zero_out), 64'd0);
        check("rst_one", 64'(alu_one), 64'd0);
        check("rst_two", 64'(alu_two), 64'd0);
        check("rst_code", 64'(alu_code), 64'(C_IDLE));
        reset = 1'b0;
        tick();

        single_op("t1", 1'b0, 32'd15, 32'd15, C_ADD, 32'd30, 1'b0);
        single_op("t2", 1'b1, 32'd0, 32'd7, C_MOV, 32'd0, 1'b1);

        a0 = 32'd1; b0 = 32'd2; code0 = C_ADD;
        a1 = 32'd9; b1 = 32'd4; code1 = C_SUB;
        tie_run("t3", 4, 32'd3, 1'b0, 32'd5, 1'b0);

        // busy: req1 appears while port 0's op is in flight
        set_req(1'b0, 32'd20, 32'd6, C_SUB);
        push_exp(1'b0, 32'd14, 1'b0);
        tick();
        check("t4_gnt0_c1", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        tick();
        set_req(1'b1, 32'd10, 32'd5, C_SUB);
        push_exp(1'b1, 32'd5, 1'b0);
        check("t4_gnt1_c2", 64'(gnt1), 64'd0);
        tick();
        check("t4_gnt1_c3", 64'(gnt1), 64'd0);
        check("t4_done0_c3", 64'(done0), 64'd1);
        tick();
        check("t4_gnt1_c4", 64'(gnt1), 64'd1);
        check("t4_one_c4", 64'(alu_one), 64'd10);
        check("t4_two_c4", 64'(alu_two), 64'd5);
        req1 = 1'b0;
        tick();
        tick();
        check("t4_done1_c6", 64'(done1), 64'd1);
        tick();

        // reset while the op is in ISSUE
        set_req(1'b0, 32'd3, 32'd4, C_ADD);
        tick();
        check("t5_gnt0_c1", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        reset = 1'b1;
        last_port = 1'b1;
        #1;
        check("t5_rst_gnt", 64'(gnt0), 64'd0);
        check("t5_rst_res", 64'(res_out), 64'd0);
        check("t5_rst_zero", 64'(zero_out), 64'd0);
        check("t5_rst_code", 64'(alu_code), 64'(C_IDLE));
        check("t5_rst_one", 64'(alu_one), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", 64'(done0 | done1), 64'd0);
        end
        reset = 1'b0;
        tick();
        single_op("t5b", 1'b0, 32'd3, 32'd4, C_ADD, 32'd7, 1'b0);

        for (int i = 0; i < 10; i++) begin
            tick();
            check("t6_res", 64'(res_out), 64'd7);
            check("t6_zero", 64'(zero_out), 64'd0);
            check("t6_code", 64'(alu_code), 64'(C_IDLE));
            check("t6_one", 64'(alu_one), 64'd3);
            check("t6_pulses", 64'({gnt0, gnt1, done0, done1}), 64'd0);
        end

        // first tie after reset goes to port 0
        reset = 1'b1;
        last_port = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        a0 = 32'd5; b0 = 32'd5; code0 = C_ADD;
        a1 = 32'd8; b1 = 32'd8; code1 = C_SUB;
        tie_run("t7", 2, 32'd10, 1'b0, 32'd0, 1'b1);

        tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
